// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a req/ack data bus and stalling the pipeline until completion.
module mem_stage_lsu #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic        ByteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        BusFaultM,
   output logic        StallM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic          r_fault, r_load, r_byte;
   logic [1:0]    r_lane;
   logic          w_access, w_mis, w_tmo;
   logic [31:0]   w_shift;
   assign w_access = MemReadM | MemWriteM;
   assign w_mis    = ~ByteM & (|ALUResultM[1:0]);
   assign w_tmo    = ~mem_ack & (r_cnt == CW'(TIMEOUT - 1));
   assign w_shift  = mem_rdata >> {r_lane, 3'b000};
   always_ff @(posedge clk)
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   always_comb begin
      w_next    = r_state;
      StallM    = 1'b0;
      BusFaultM = 1'b0;
      case (r_state)
         IDLE: begin
            StallM = w_access;
            w_next = w_access ? (w_mis ? DONE : ACCESS) : IDLE;
         end
         ACCESS: begin
            StallM = 1'b1;
            w_next = (mem_ack | w_tmo) ? DONE : ACCESS;
         end
         DONE: begin
            BusFaultM = r_fault;
            w_next    = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end
   // The access shape is latched at issue so completion does not depend on the stalled inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         ReadDataM <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         r_cnt     <= '0;
         r_fault   <= 1'b0;
         r_load    <= 1'b0;
         r_byte    <= 1'b0;
         r_lane    <= '0;
      end else if (r_state == IDLE) begin
         if (w_access) begin
            r_fault <= w_mis;
            if (!w_mis) begin
               mem_req   <= 1'b1;
               mem_we    <= MemWriteM;
               mem_addr  <= {ALUResultM[31:2], 2'b00};
               mem_be    <= ByteM ? 4'b0001 << ALUResultM[1:0] : 4'hF;
               mem_wdata <= ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
               r_cnt     <= '0;
               r_load    <= ~MemWriteM;
               r_byte    <= ByteM;
               r_lane    <= ALUResultM[1:0];
            end
         end
      end else if (r_state == ACCESS) begin
         r_cnt <= r_cnt + CW'(1);
         if (mem_ack) begin
            mem_req <= 1'b0;
            r_fault <= 1'b0;
            if (r_load) ReadDataM <= r_byte ? {24'b0, w_shift[7:0]} : mem_rdata;
         end else if (w_tmo) begin
            mem_req <= 1'b0;
            r_fault <= 1'b1;
            if (r_load) ReadDataM <= '0;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed scoreboard bench for the MEM-stage load/store unit.
module tb_mem_stage_lsu;
   logic        clk = 0, reset = 1;
   logic        MemReadM = 0, MemWriteM = 0, ByteM = 0;
   logic [31:0] ALUResultM = 0, WriteDataM = 0, mem_rdata = 0;
   logic        mem_ack = 0;
   logic [31:0] ReadDataM, mem_addr, mem_wdata;
   logic        BusFaultM, StallM, mem_req, mem_we;
   logic [3:0]  mem_be;
   int          total = 0, passed = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
      logic [7:0]  stalls;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_t;
   exp_t q[$];

   mem_stage_lsu #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ByteM(ByteM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
      .BusFaultM(BusFaultM), .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // ack_at = ACCESS cycle on which mem_ack pulses (0 = never)
   task automatic run(input string tag, input bit rd, input bit wr, input bit by,
                      input logic [31:0] addr, input logic [31:0] wd, input int ack_at,
                      input logic [31:0] rdat, input exp_t e);
      exp_t        x;
      int          st = 0, acc = 0;
      bit          done = 0, seen = 0;
      logic        we_o = 0;
      logic [31:0] a_o = 0, wd_o = 0;
      logic [3:0]  be_o = 0;
      q.push_back(e);
      @(negedge clk);
      MemReadM = rd; MemWriteM = wr; ByteM = by; ALUResultM = addr; WriteDataM = wd; mem_rdata = rdat;
      #1;
      for (int c = 0; c < 64 && !done; c++) begin
         if (StallM) begin
            st++;
            if (mem_req) begin
               acc++;
               if (!seen) begin
                  seen = 1; we_o = mem_we; a_o = mem_addr; wd_o = mem_wdata; be_o = mem_be;
               end
            end
            mem_ack = mem_req && (acc == ack_at);
            @(negedge clk); #1;
         end else begin
            mem_ack = 0;
            x = q.pop_front();
            chk({tag, "_rdata"}, ReadDataM, x.rdata);
            chk({tag, "_fault"}, 32'(BusFaultM), 32'(x.fault));
            chk({tag, "_stalls"}, 32'(st), 32'(x.stalls));
            chk({tag, "_req_seen"}, 32'(seen), 32'(x.req));
            chk({tag, "_req_dropped"}, 32'(mem_req), 0);
            if (x.req) begin
               chk({tag, "_we"}, 32'(we_o), 32'(x.we));
               chk({tag, "_addr"}, a_o, x.addr);
               chk({tag, "_be"}, 32'(be_o), 32'(x.be));
               chk({tag, "_wdata"}, wd_o, x.wdata);
            end
            done = 1;
            MemReadM = 0; MemWriteM = 0; ByteM = 0; ALUResultM = 0; WriteDataM = 0;
         end
      end
      if (!done) begin
         total++;
         $error("FAIL %s_no_done: got stall after %0d cycles expected DONE", tag, st);
         void'(q.pop_front());
         MemReadM = 0; MemWriteM = 0; mem_ack = 0;
      end
      @(negedge clk); #1;
      chk({tag, "_idle_fault"}, 32'(BusFaultM), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", 32'(StallM), 0);
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_rdata", ReadDataM, 0);
      chk("rst_fault", 32'(BusFaultM), 0);
      reset = 0;
      run("wload", 1, 0, 0, 32'h104, 0, 3, 32'hDEADBEEF,
          '{32'hDEADBEEF, 1'b0, 8'd4, 1'b1, 1'b0, 32'h104, 4'hF, 32'h0});
      run("bstore", 0, 1, 1, 32'h202, 32'h123456AB, 1, 32'h0,
          '{32'hDEADBEEF, 1'b0, 8'd2, 1'b1, 1'b1, 32'h200, 4'b0100, 32'hABABABAB});
      run("bload", 1, 0, 1, 32'h303, 0, 1, 32'h80FF0011,
          '{32'h00000080, 1'b0, 8'd2, 1'b1, 1'b0, 32'h300, 4'b1000, 32'h0});
      run("misal", 1, 0, 0, 32'h6, 0, 1, 32'h0,
          '{32'h00000080, 1'b1, 8'd1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0});
      run("st_tmo", 0, 1, 0, 32'h10, 32'h77, 0, 32'h0,
          '{32'h00000080, 1'b1, 8'd17, 1'b1, 1'b1, 32'h10, 4'hF, 32'h77});
      run("ld_tmo", 1, 0, 0, 32'h20, 0, 0, 32'h0,
          '{32'h0, 1'b1, 8'd17, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0});
      run("ld_ack16", 1, 0, 0, 32'h24, 0, 16, 32'h55AA55AA,
          '{32'h55AA55AA, 1'b0, 8'd17, 1'b1, 1'b0, 32'h24, 4'hF, 32'h0});
      run("rdwr", 1, 1, 0, 32'h30, 32'hCAFEF00D, 1, 32'h99999999,
          '{32'h55AA55AA, 1'b0, 8'd2, 1'b1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D});
      // Reset on the second ACCESS cycle
      @(negedge clk);
      MemReadM = 1; ALUResultM = 32'h44; #1;
      repeat (2) begin @(negedge clk); #1; end
      chk("mid_req_before", 32'(mem_req), 1);
      reset = 1; MemReadM = 0; ALUResultM = 0;
      @(negedge clk); #1;
      chk("mid_req", 32'(mem_req), 0);
      chk("mid_stall", 32'(StallM), 0);
      chk("mid_rdata", ReadDataM, 0);
      chk("mid_fault", 32'(BusFaultM), 0);
      chk("mid_addr", mem_addr, 0);
      chk("mid_be", 32'(mem_be), 0);
      chk("mid_we", 32'(mem_we), 0);
      reset = 0;
      run("post_rst", 1, 0, 0, 32'h40, 0, 2, 32'h11223344,
          '{32'h11223344, 1'b0, 8'd3, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0});
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
